div_unit: RTL and testbench

- Multi-cycle radix-2 restoring integer divider for DIV/DIVU instructions.
- Sits in the EX stage beside the ALU. The decoder issues a divide without asserting regWrite; this block computes quotient/remainder into HI/LO while holding the pipeline via busy.
- Responder side of the decoder's divide-issue interface.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 27 ++
 rtl/div_unit.sv | 113 +++++++++++
 tb/tb_div_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the integer divide unit: FSM encoding, default width,
// and the decoder funct codes that route DIV/DIVU here.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    // Primary opcodes and SPECIAL funct codes seen by the decoder
    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_REGIMM   = 6'h01;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift {rem,quot} left, trial-subtract the
// divisor with one guard bit, keep the difference only when it is non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quot_nxt
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted  = {rem, quot[WIDTH-1]};
        diff     = shifted - {1'b0, dsr};
        rem_nxt  = shifted[WIDTH-1:0];
        quot_nxt = {quot[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_nxt  = diff[WIDTH-1:0];
            quot_nxt = {quot[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, writing HI/LO.
// Optional macro DIV_EARLY_OUT_EN: skip iterations when divisor==0 or |a|<|b|.
module div_unit
    import div_pkg::*;
#(
    parameter  int WIDTH = DIV_WIDTH,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quot, dsr, dvd_orig;
    logic [WIDTH-1:0] rem_step, quot_step;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             neg_q, neg_r, dz;
    logic             accept, early;

    // Most-negative value maps to itself, which is correct read as unsigned
    assign a_mag  = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign b_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    assign accept = (state == S_IDLE) && start && !flush;
    assign busy   = (state != S_IDLE);

`ifdef DIV_EARLY_OUT_EN
    assign early = (divisor == '0) || (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quot     (quot),
        .dsr      (dsr),
        .rem_nxt  (rem_step),
        .quot_nxt (quot_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = early ? S_FIX : S_RUN;
            S_RUN: begin
                if (flush)                   state_nxt = S_IDLE;
                else if (cnt == CNT_W'(1))   state_nxt = S_FIX;
            end
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem         <= '0;
            quot        <= '0;
            dsr         <= '0;
            dvd_orig    <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    // Early-out preloads the final quotient/remainder directly
                    rem      <= early ? a_mag : '0;
                    quot     <= early ? '0 : a_mag;
                    dsr      <= b_mag;
                    dvd_orig <= dividend;
                    cnt      <= CNT_W'(WIDTH);
                    neg_q    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_r    <= is_signed & dividend[WIDTH-1];
                    dz       <= (divisor == '0);
                end
                S_RUN: if (!flush) begin
                    rem  <= rem_step;
                    quot <= quot_step;
                    cnt  <= cnt - 1'b1;
                end
                S_FIX: if (!flush) begin
                    done        <= 1'b1;
                    div_by_zero <= dz;
                    lo          <= dz ? '1 : (neg_q ? -quot : quot);
                    hi          <= dz ? dvd_orig : (neg_r ? -rem : rem);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed corner cases plus random operands,
// checked against a plain-arithmetic reference model.
module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
        int           sc;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [W-1:0] last_lo = '0;
    logic [W-1:0] last_hi = '0;
    logic         last_dz = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division semantics plus the divide-by-zero rule
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t   e;
        longint sa, sb_;
        logic [W-1:0] ma, mb;
        if (b == 0) begin
            e.lo = '1; e.hi = a; e.dz = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb_ = longint'($signed(b));
            e.lo = W'(sa / sb_);
            e.hi = W'(sa % sb_);
            e.dz = 1'b0;
        end else begin
            e.lo = a / b; e.hi = a % b; e.dz = 1'b0;
        end
        ma = (s && a[W-1]) ? -a : a;
        mb = (s && b[W-1]) ? -b : b;
        e.lat = W + 1;
`ifdef DIV_EARLY_OUT_EN
        if (b == 0 || ma < mb) e.lat = 1;
`endif
        e.sc = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done actual=1 expected=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("lo", lo, e.lo);
                check("hi", hi, e.hi);
                check("div_by_zero", div_by_zero, e.dz);
                check("latency", cyc - e.sc, e.lat);
                last_lo = e.lo;
                last_hi = e.hi;
                last_dz = e.dz;
            end
        end
    end

    task automatic wait_idle(input int exp_busy);
        int bc = 0;
        for (int i = 0; i < 200 && busy; i++) begin
            bc++;
            @(negedge clk);
        end
        check("busy_cycles", bc, exp_busy);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        @(negedge clk);
        dividend = a; divisor = b; is_signed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = model(a, b, s);
        e.sc = cyc;
        sb.push_back(e);
        wait_idle(e.lat);
    endtask

    task automatic start_and_abort(input logic use_reset);
        @(negedge clk);
        dividend = 100; divisor = 7; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        if (use_reset) begin
            rst_n = 1'b0;
            #1;
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_lo", lo, 0);
            check("rst_hi", hi, 0);
            check("rst_dz", div_by_zero, 0);
            last_lo = '0; last_hi = '0; last_dz = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            check("flush_busy", busy, 0);
            check("flush_lo", lo, last_lo);
            check("flush_hi", hi, last_hi);
            check("flush_dz", div_by_zero, last_dz);
        end
        repeat (W + 5) @(negedge clk);
    endtask

    initial begin
        exp_t e1, e2;
        logic [W-1:0] a, b;

        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_lo", lo, 0);
        check("reset_hi", hi, 0);
        check("reset_dz", div_by_zero, 0);
        rst_n = 1'b1;

        issue(32'd100, 32'd7, 1'b0);
        issue(32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(32'd7, 32'hFFFF_FFFE, 1'b1);
        issue(32'd5, 32'd0, 1'b1);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(32'hFFFF_FFF9, 32'd0, 1'b0);
        issue(32'd3, 32'd9, 1'b0);
        issue(32'hFFFF_FFFF, 32'd1, 1'b0);

        start_and_abort(1'b0);
        start_and_abort(1'b1);
        issue(32'd77, 32'd10, 1'b0);

        // start held high across two operations
        @(negedge clk);
        dividend = 50; divisor = 5; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        e1 = model(50, 5, 1'b0);
        e1.sc = cyc;
        sb.push_back(e1);
        dividend = 9; divisor = 4;
        wait_idle(e1.lat);
        @(negedge clk);
        start = 1'b0;
        e2 = model(9, 4, 1'b0);
        e2.sc = cyc;
        sb.push_back(e2);
        wait_idle(e2.lat);

        // start and flush together in IDLE: flush wins
        @(negedge clk);
        dividend = 8; divisor = 2; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("start_flush_busy", busy, 0);
        repeat (W + 4) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom_range(0, 3);
                1: b = $urandom & 32'h0000_FFFF;
                2: b = $urandom;
                3: b = -$urandom_range(1, 9);
                default: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            endcase
            if ($urandom_range(0, 5) == 0) a = $urandom_range(0, 20);
            issue(a, b, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
